strait_test_ctrl: RTL and testbench

- Self-test sequencer for the systolic array and its eNVM.
- On start, steps through every stuck-at (SA) pattern, then every transition-delay (TD) pattern, by driving test_type/test_counter to the eNVM and pulsing the array.
- Collects per-row mismatch vectors into an internal fault map.
- Writes the map, plus row/column fault verdicts, back into the eNVM through its detection write port, one row address per cycle.

---
 rtl/strait_test_ctrl.sv | 173 +++++++++++++++++
 tb/tb_strait_test_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strait_test_ctrl.sv
// strait_test_ctrl: self-test sequencer for the systolic array and its eNVM.
// Runs every SA then TD pattern, builds a fault map and writes it back.
module strait_test_ctrl #(
    parameter int SYSTOLIC_SIZE         = 8,
    parameter int ADDR_WIDTH            = $clog2(SYSTOLIC_SIZE),
    parameter int SA_TEST_PATTERN_DEPTH = 12,
    parameter int TD_TEST_PATTERN_DEPTH = 18,
    parameter int MAX_ADDR_WIDTH        = $clog2(
        (SA_TEST_PATTERN_DEPTH > TD_TEST_PATTERN_DEPTH) ?
        SA_TEST_PATTERN_DEPTH : TD_TEST_PATTERN_DEPTH),
    parameter int ROW_FAULT_THRESH      = 2,
    parameter int COL_FAULT_THRESH      = 2,
    parameter int TIMEOUT_CYCLES        = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic                      test_type,
    output logic [MAX_ADDR_WIDTH-1:0] test_counter,
    output logic                      pattern_start,
    input  logic                      res_valid,
    input  logic [SYSTOLIC_SIZE-1:0]  res_mismatch,
    output logic                      detection_en,
    output logic [ADDR_WIDTH-1:0]     detection_addr,
    output logic [SYSTOLIC_SIZE-1:0]  single_pe_detection,
    output logic                      row_fault_detection,
    output logic                      column_fault_detection,
    output logic                      busy,
    output logic                      done,
    output logic                      fault_found,
    output logic                      timeout_err
);
    localparam int N   = SYSTOLIC_SIZE;
    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(N - 1);
    localparam logic [MAX_ADDR_WIDTH-1:0] SA_LAST =
        MAX_ADDR_WIDTH'(SA_TEST_PATTERN_DEPTH - 1);
    localparam logic [MAX_ADDR_WIDTH-1:0] TD_LAST =
        MAX_ADDR_WIDTH'(TD_TEST_PATTERN_DEPTH - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, COLLECT, WRITEBACK, DONE
    } state_t;

    state_t                      state, state_n;
    logic [N-1:0]                fmap   [N];
    logic [N-1:0]                fmap_n [N];
    logic [ADDR_WIDTH-1:0]       beat_cnt, beat_n;
    logic [ADDR_WIDTH-1:0]       addr, addr_n;
    logic [WDW-1:0]              wd_cnt, wd_n;
    logic                        type_n, terr_n, any_n, wb_n;
    logic [MAX_ADDR_WIDTH-1:0]   cnt_n;
    int                          row_cnt, col_cnt;

    always_comb begin
        state_n = state;
        fmap_n  = fmap;
        beat_n  = beat_cnt;
        addr_n  = addr;
        wd_n    = wd_cnt;
        type_n  = test_type;
        cnt_n   = test_counter;
        terr_n  = timeout_err;
        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n = ISSUE;
                        for (int r = 0; r < N; r++) fmap_n[r] = '0;
                        type_n  = 1'b0;
                        cnt_n   = '0;
                        terr_n  = 1'b0;
                    end
                end
                ISSUE: begin
                    state_n = COLLECT;
                    beat_n  = '0;
                    wd_n    = '0;
                end
                COLLECT: begin
                    if (res_valid) begin
                        fmap_n[beat_cnt] = fmap[beat_cnt] | res_mismatch;
                        beat_n = beat_cnt + 1'b1;
                        wd_n   = '0;
                        if (beat_cnt == LAST_ROW) begin
                            state_n = ISSUE;
                            if (!test_type) begin
                                if (test_counter < SA_LAST) begin
                                    cnt_n = test_counter + 1'b1;
                                end else begin
                                    type_n = 1'b1;
                                    cnt_n  = '0;
                                end
                            end else if (test_counter < TD_LAST) begin
                                cnt_n = test_counter + 1'b1;
                            end else begin
                                state_n = WRITEBACK;
                                addr_n  = '0;
                            end
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        // Stalled array: still write back what was seen
                        terr_n  = 1'b1;
                        state_n = WRITEBACK;
                        addr_n  = '0;
                    end else begin
                        wd_n = wd_cnt + 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (addr == LAST_ROW) state_n = DONE;
                    else addr_n = addr + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end

        wb_n    = (state_n == WRITEBACK);
        any_n   = 1'b0;
        row_cnt = 0;
        col_cnt = 0;
        for (int r = 0; r < N; r++) begin
            any_n   = any_n | (|fmap_n[r]);
            col_cnt = col_cnt + int'(fmap_n[r][addr_n]);
            row_cnt = row_cnt + int'(fmap_n[addr_n][r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            for (int r = 0; r < N; r++) fmap[r] <= '0;
            beat_cnt               <= '0;
            addr                   <= '0;
            wd_cnt                 <= '0;
            test_type              <= 1'b0;
            test_counter           <= '0;
            timeout_err            <= 1'b0;
            pattern_start          <= 1'b0;
            detection_en           <= 1'b0;
            detection_addr         <= '0;
            single_pe_detection    <= '0;
            row_fault_detection    <= 1'b0;
            column_fault_detection <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            fault_found            <= 1'b0;
        end else begin
            state                  <= state_n;
            fmap                   <= fmap_n;
            beat_cnt               <= beat_n;
            addr                   <= addr_n;
            wd_cnt                 <= wd_n;
            test_type              <= type_n;
            test_counter           <= cnt_n;
            timeout_err            <= terr_n;
            pattern_start          <= (state_n == ISSUE);
            detection_en           <= wb_n;
            detection_addr         <= wb_n ? addr_n : '0;
            single_pe_detection    <= wb_n ? fmap_n[addr_n] : '0;
            row_fault_detection    <= wb_n && (row_cnt >= ROW_FAULT_THRESH);
            column_fault_detection <= wb_n && (col_cnt >= COL_FAULT_THRESH);
            busy                   <= (state_n == ISSUE) ||
                                      (state_n == COLLECT) || wb_n;
            done                   <= (state_n == DONE) && (state != DONE);
            fault_found            <= (state_n == DONE) && any_n;
        end
    end
endmodule

// File: tb/tb_strait_test_ctrl.sv
// Bench for strait_test_ctrl: array model with fault injection, pattern
// scoreboard queue and a table of fault scenarios with hand-derived verdicts.
module tb_strait_test_ctrl;
    localparam int N   = 8;
    localparam int SA  = 12;
    localparam int TD  = 18;
    localparam int TO  = 64;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       res_valid = 1'b0;
    logic [7:0] res_mismatch = 8'h00;
    logic       test_type;
    logic [4:0] test_counter;
    logic       pattern_start;
    logic       detection_en;
    logic [2:0] detection_addr;
    logic [7:0] single_pe_detection;
    logic       row_fault_detection;
    logic       column_fault_detection;
    logic       busy;
    logic       done;
    logic       fault_found;
    logic       timeout_err;
    logic [24:0] outs;

    always #5 clk = ~clk;

    strait_test_ctrl #(
        .SYSTOLIC_SIZE(N), .ADDR_WIDTH(3),
        .SA_TEST_PATTERN_DEPTH(SA), .TD_TEST_PATTERN_DEPTH(TD),
        .MAX_ADDR_WIDTH(5), .ROW_FAULT_THRESH(2),
        .COL_FAULT_THRESH(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .test_type(test_type), .test_counter(test_counter),
        .pattern_start(pattern_start), .res_valid(res_valid),
        .res_mismatch(res_mismatch), .detection_en(detection_en),
        .detection_addr(detection_addr),
        .single_pe_detection(single_pe_detection),
        .row_fault_detection(row_fault_detection),
        .column_fault_detection(column_fault_detection),
        .busy(busy), .done(done), .fault_found(fault_found),
        .timeout_err(timeout_err)
    );

    assign outs = {test_type, test_counter, pattern_start, detection_en,
                   detection_addr, single_pe_detection, row_fault_detection,
                   column_fault_detection, busy, done, fault_found,
                   timeout_err};

    // Up to two injected mismatches {type, counter, row, bits}, an
    // optional array stall (TD pattern 4 after 3 beats), expected verdicts.
    typedef struct {
        logic t0; int c0; int r0; logic [7:0] m0;
        logic t1; int c1; int r1; logic [7:0] m1;
        logic stop; logic found; logic [7:0] rowf; logic [7:0] colf;
    } vec_t;

    vec_t       vecs [8];
    vec_t       cur;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [5:0] pat_q [$];
    logic [7:0] model_map [N];
    int         wb_idx = 0;
    bit         mon_en = 0;
    bit         stray_req = 0;
    bit         ps_prev = 0;
    time        last_beat_t = 0;
    int         a_wait = 0;
    int         a_row = 0;
    bit         a_busy = 0;
    logic       a_t = 1'b0;
    int         a_c = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [7:0] inj(logic t, int c, int r);
        logic [7:0] m;
        m = 8'h00;
        if (cur.t0 == t && cur.c0 == c && cur.r0 == r) m = m | cur.m0;
        if (cur.t1 == t && cur.c1 == c && cur.r1 == r) m = m | cur.m1;
        return m;
    endfunction

    // Array model: LAT idle cycles after each pulse, then N row beats
    initial begin
        forever begin
            @(negedge clk);
            res_valid    = 1'b0;
            res_mismatch = 8'h00;
            if (!rst_n) begin
                a_busy = 0;
            end else if (stray_req) begin
                res_valid    = 1'b1;
                res_mismatch = 8'hFF;
                stray_req    = 0;
            end else if (pattern_start) begin
                a_busy = 1;
                a_wait = LAT;
                a_row  = 0;
                a_t    = test_type;
                a_c    = int'(test_counter);
            end else if (a_busy) begin
                if (a_wait > 0) begin
                    a_wait--;
                end else if (cur.stop && a_t && a_c == 4 && a_row == 3) begin
                    a_busy = 0;
                end else begin
                    chk("tt_stable", {26'd0, test_type, test_counter},
                        {26'd0, a_t, 5'(a_c)});
                    res_valid    = 1'b1;
                    res_mismatch = inj(a_t, a_c, a_row);
                    model_map[a_row] = model_map[a_row] | res_mismatch;
                    last_beat_t = $time;
                    a_row++;
                    if (a_row == N) a_busy = 0;
                end
            end
        end
    end

    // Output monitor: pattern scoreboard and writeback checks
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pattern_start) begin
                    chk("ps_width", 32'(ps_prev), 0);
                    if (pat_q.size() == 0) begin
                        chk("ps_extra", 1, 0);
                    end else begin
                        e = pat_q.pop_front();
                        chk("ps_type", 32'(test_type), 32'(e[5]));
                        chk("ps_cnt", 32'(test_counter), 32'(e[4:0]));
                    end
                end
                if (detection_en) begin
                    if (wb_idx < N) begin
                        chk("wb_addr", 32'(detection_addr), wb_idx);
                        chk("wb_pe", 32'(single_pe_detection),
                            32'(model_map[wb_idx]));
                        chk("wb_row", 32'(row_fault_detection),
                            32'(cur.rowf[wb_idx]));
                        chk("wb_col", 32'(column_fault_detection),
                            32'(cur.colf[wb_idx]));
                        if (wb_idx == 0 && cur.stop)
                            chk("wd_gap", 32'((($time - last_beat_t) / 10)),
                                1 + TO);
                    end else begin
                        chk("wb_extra", 1, 0);
                    end
                    wb_idx++;
                end
                if (done) chk("done_after_wb", wb_idx, N);
            end
            ps_prev = pattern_start;
        end
    end

    task automatic arm(input vec_t v);
        int np;
        cur = v;
        for (int r = 0; r < N; r++) model_map[r] = 8'h00;
        wb_idx = 0;
        pat_q.delete();
        np = v.stop ? SA + 5 : SA + TD;
        for (int k = 0; k < np; k++)
            pat_q.push_back(k < SA ? {1'b0, 5'(k)} : {1'b1, 5'(k - SA)});
        mon_en = 1;
    endtask

    task automatic run_vec(input vec_t v, input bit dbl);
        int cyc;
        bit seen;
        bit armd;
        arm(v);
        @(negedge clk);
        start = 1'b1;
        cyc  = 0;
        seen = 0;
        armd = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = armd;
            armd  = dbl && pattern_start && !test_type && test_counter == 3;
            if (cyc == 1) begin
                chk("start_busy", 32'(busy), 1);
                chk("start_clr_to", 32'(timeout_err), 0);
            end
            if (done) seen = 1;
        end
        start  = 1'b0;
        mon_en = 0;
        chk("done_seen", 32'(seen), 1);
        chk("wb_count", wb_idx, N);
        chk("pat_left", pat_q.size(), 0);
        chk("fault_found", 32'(fault_found), 32'(v.found));
        chk("timeout_err", 32'(timeout_err), 32'(v.stop));
        chk("busy_done", 32'(busy), 0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("found_held", 32'(fault_found), 32'(v.found));
    endtask

    initial begin
        int  cyc;
        bit  hit;
        bit  bad;
        vecs[0] = '{1'b0, 0, 0, 8'h00, 1'b0, 0, 0, 8'h00,
                    1'b0, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 5, 3, 8'h10, 1'b0, 0, 0, 8'h00,
                    1'b0, 1'b1, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 0, 2, 8'h03, 1'b0, 0, 0, 8'h00,
                    1'b0, 1'b1, 8'h04, 8'h00};
        vecs[3] = '{1'b0, 2, 0, 8'h80, 1'b1, 7, 6, 8'h80,
                    1'b0, 1'b1, 8'h00, 8'h80};
        vecs[4] = '{1'b0, 11, 1, 8'h01, 1'b1, 17, 4, 8'h01,
                    1'b0, 1'b1, 8'h00, 8'h01};
        vecs[5] = '{1'b1, 0, 7, 8'hFF, 1'b0, 0, 0, 8'h00,
                    1'b0, 1'b1, 8'h80, 8'h00};
        vecs[6] = '{1'b0, 3, 5, 8'h01, 1'b1, 9, 5, 8'h20,
                    1'b0, 1'b1, 8'h20, 8'h00};
        vecs[7] = '{1'b1, 4, 1, 8'h06, 1'b0, 0, 0, 8'h00,
                    1'b1, 1'b1, 8'h02, 8'h00};
        cur = vecs[0];

        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(outs), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", 32'(outs), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0);

        // After the timeout scenario: start clears it; mid-run start ignored
        run_vec(vecs[0], 1'b1);

        // Abort during TD collection
        arm(vecs[0]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        cyc = 0;
        while (!hit && cyc < 2000) begin
            if (pattern_start && test_type && test_counter == 2) hit = 1;
            else begin @(negedge clk); cyc++; end
        end
        chk("abort_reach", 32'(hit), 1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ps", 32'(pattern_start), 0);
        chk("abort_det", 32'(detection_en), 0);
        chk("abort_done", 32'(done), 0);
        mon_en = 0;
        pat_q.delete();
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (detection_en || done || busy) bad = 1;
        end
        chk("abort_quiet", 32'(bad), 0);

        // start and abort together: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", 32'(busy), 0);
        run_vec(vecs[0], 1'b0);

        // Stray result beat while idle
        @(posedge clk);
        stray_req = 1;
        repeat (3) @(negedge clk);
        chk("stray_idle", 32'(busy), 0);
        run_vec(vecs[0], 1'b0);

        // Asynchronous reset in the middle of writeback
        arm(vecs[1]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        cyc = 0;
        while (!hit && cyc < 2000) begin
            if (detection_en && detection_addr == 3'd4) hit = 1;
            else begin @(negedge clk); cyc++; end
        end
        chk("rst_reach", 32'(hit), 1);
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        chk("rst_async", 32'(outs), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (detection_en || busy || done) bad = 1;
        end
        chk("rst_quiet", 32'(bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL global_timeout: got running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
